bwt_string_loader: RTL

//  Upstream feeder for the BWT core: accepts a byte stream (valid/ready/last), packs it

---
 rtl/bwt_string_loader_if.sv | 22 ++
 rtl/bwt_string_loader.sv | 139 +++++++++++++
 2 files changed

// File: rtl/bwt_string_loader_if.sv
// Host byte-stream handshake into the BWT string loader.
// Master drives payload bytes; slave returns ready.
interface bwt_string_loader_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;

    modport master (
        output s_data,
        output s_valid,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/bwt_string_loader.sv
// Packs a host byte stream into the BWT core's string vector,
// appends the terminator, pads, then runs the core start handshake.
module bwt_string_loader #(
    parameter int         STRING_LEN = 32,
    parameter logic [7:0] TERMINATOR = 8'h24,
    parameter logic [7:0] PAD_CHAR   = 8'h00,
    parameter int         HOLDOFF    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    bwt_string_loader_if.slave            s,
    output logic [8*STRING_LEN-1:0]       string_out,
    output logic                          start_out,
    input  logic                          bwt_valid_in,
    output logic                          busy,
    output logic [$clog2(STRING_LEN)-1:0] len_out,
    output logic                          trunc_err
);
    localparam int CW = $clog2(STRING_LEN);
    localparam int HW = $clog2(HOLDOFF + 1);
    localparam logic [CW-1:0] LAST_LANE = CW'(STRING_LEN - 1);
    localparam logic [CW-1:0] FULL_CTR  = CW'(STRING_LEN - 2);
    localparam logic [HW-1:0] HOLD_END  = HW'(HOLDOFF - 1);

    typedef enum logic [2:0] {
        FILL, DRAIN, PAD, START, WAIT_VALID, HOLD
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] ctr, ctr_n;
    logic [CW-1:0] len_n;
    logic [HW-1:0] hcnt, hcnt_n;
    logic          start_n;
    logic          busy_n;
    logic          trunc_n;
    logic          lane_we;
    logic [7:0]    lane_data;
    logic          accept;

    assign s.s_ready = !rst && (state == FILL || state == DRAIN);
    assign accept    = s.s_valid && s.s_ready;

    // Next-state and lane-write decode; every field holds by default.
    always_comb begin
        state_n   = state;
        ctr_n     = ctr;
        len_n     = len_out;
        hcnt_n    = hcnt;
        start_n   = start_out;
        busy_n    = busy;
        trunc_n   = trunc_err;
        lane_we   = 1'b0;
        lane_data = s.s_data;
        unique case (state)
            FILL: begin
                if (accept) begin
                    lane_we = 1'b1;
                    ctr_n   = ctr + 1'b1;
                    busy_n  = 1'b1;
                    if (ctr == '0)
                        trunc_n = 1'b0;
                    if (s.s_last) begin
                        state_n = PAD;
                        len_n   = ctr + 1'b1;
                    end else if (ctr == FULL_CTR) begin
                        state_n = DRAIN;
                        trunc_n = 1'b1;
                        len_n   = LAST_LANE;
                    end
                end
            end
            DRAIN: begin
                if (accept && s.s_last)
                    state_n = PAD;
            end
            PAD: begin
                lane_we   = 1'b1;
                lane_data = (ctr == len_out) ? TERMINATOR : PAD_CHAR;
                if (ctr == LAST_LANE)
                    state_n = START;
                else
                    ctr_n = ctr + 1'b1;
            end
            START: begin
                start_n = 1'b1;
                state_n = WAIT_VALID;
            end
            WAIT_VALID: begin
                if (bwt_valid_in) begin
                    start_n = 1'b0;
                    hcnt_n  = '0;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (hcnt == HOLD_END) begin
                    state_n = FILL;
                    ctr_n   = '0;
                    busy_n  = 1'b0;
                end else begin
                    hcnt_n = hcnt + 1'b1;
                end
            end
            default: state_n = FILL;
        endcase
    end

    // Control and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            ctr       <= '0;
            hcnt      <= '0;
            start_out <= 1'b0;
            busy      <= 1'b0;
            len_out   <= '0;
            trunc_err <= 1'b0;
        end else begin
            state     <= state_n;
            ctr       <= ctr_n;
            hcnt      <= hcnt_n;
            start_out <= start_n;
            busy      <= busy_n;
            len_out   <= len_n;
            trunc_err <= trunc_n;
        end
    end

    // String vector: one lane written per cycle at lane ctr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            string_out <= '0;
        end else if (lane_we) begin
            for (int k = 0; k < STRING_LEN; k++)
                if (ctr == CW'(k))
                    string_out[8*k +: 8] <= lane_data;
        end
    end
endmodule
